// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, next-address select and run/halt sequencing
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             halt_req,
  input  logic             is_jmp,
  input  logic             is_call,
  input  logic             valid_jmp,
  input  logic [31:0]      jmp_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             link_we,
  output logic [31:0]      link_addr,
  output logic             fetch_valid,
  output logic             halted,
  output logic             align_err,
  output logic [31:0]      instr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t           state, state_next;
  logic [31:0]      pc_next;
  logic [31:0]      instr_cnt_next;
  logic [CNT_W-1:0] taken_cnt_next;
  logic             align_err_next;
  logic             taken;
  logic             target_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      instr_cnt <= 32'd0;
      taken_cnt <= '0;
      align_err <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      instr_cnt <= instr_cnt_next;
      taken_cnt <= taken_cnt_next;
      align_err <= align_err_next;
    end
  end

  assign pc_plus4    = pc + 32'd4;
  assign link_addr   = pc_plus4;
  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);
  assign taken       = is_jmp & valid_jmp;
  assign target_ok   = (jmp_target[1:0] == 2'b00);
  assign link_we     = fetch_valid & en & taken & is_call & ~halt_req & target_ok;

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    instr_cnt_next = instr_cnt;
    taken_cnt_next = taken_cnt;
    align_err_next = align_err;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (en) begin
          if (halt_req) begin
            state_next     = HALT;
            instr_cnt_next = instr_cnt + 32'd1;
          end else if (taken) begin
            if (!target_ok) begin
              // misaligned target does not retire: counters and pc stay put
              state_next     = HALT;
              align_err_next = 1'b1;
            end else begin
              pc_next        = jmp_target;
              instr_cnt_next = instr_cnt + 32'd1;
              if (taken_cnt != '1)
                taken_cnt_next = taken_cnt + CNT_W'(1);
            end
          end else begin
            pc_next        = pc_plus4;
            instr_cnt_next = instr_cnt + 32'd1;
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        halt_req;
  logic        is_jmp;
  logic        is_call;
  logic        valid_jmp;
  logic [31:0] jmp_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        link_we;
  logic [31:0] link_addr;
  logic        fetch_valid;
  logic        halted;
  logic        align_err;
  logic [31:0] instr_cnt;
  logic [15:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .halt_req(halt_req), .is_jmp(is_jmp),
    .is_call(is_call), .valid_jmp(valid_jmp), .jmp_target(jmp_target),
    .pc(pc), .pc_plus4(pc_plus4), .link_we(link_we), .link_addr(link_addr),
    .fetch_valid(fetch_valid), .halted(halted), .align_err(align_err),
    .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; halt_req = 1'b0; is_jmp = 1'b0; is_call = 1'b0;
    valid_jmp = 1'b0; jmp_target = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'd0); end
    checks++; if (fetch_valid !== 1'b0 || halted !== 1'b0 || align_err !== 1'b0 || link_we !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got fv=%b h=%b ae=%b lw=%b want 0000", fetch_valid, halted, align_err, link_we); end
    checks++; if (instr_cnt !== 32'd0 || taken_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", instr_cnt, taken_cnt); end
    step();
    step();
    rst = 1'b1;
    // BOOT cycle
    checks++; if (fetch_valid !== 1'b0 || pc !== 32'd0) begin
      errors++; $display("FAIL boot_c0: got fv=%b pc=%h want fv=0 pc=0", fetch_valid, pc); end
    step();
    checks++; if (fetch_valid !== 1'b1 || pc !== 32'd0) begin
      errors++; $display("FAIL boot_c1: got fv=%b pc=%h want fv=1 pc=0", fetch_valid, pc); end
    step();
    checks++; if (fetch_valid !== 1'b1 || pc !== 32'd4) begin
      errors++; $display("FAIL boot_c2: got fv=%b pc=%h want fv=1 pc=4", fetch_valid, pc); end
    step();
    checks++; if (fetch_valid !== 1'b1 || pc !== 32'd8 || instr_cnt !== 32'd2) begin
      errors++; $display("FAIL boot_c3: got fv=%b pc=%h cnt=%0d want 1/8/2", fetch_valid, pc, instr_cnt); end
  endtask

  task automatic test_taken_call();
    step(); step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL call_pre_pc: got %h want 10", pc); end
    is_jmp = 1'b1; is_call = 1'b1; valid_jmp = 1'b1; jmp_target = 32'h40;
    #1;
    checks++; if (link_we !== 1'b1 || link_addr !== 32'h14) begin
      errors++; $display("FAIL call_link: got we=%b addr=%h want 1/14", link_we, link_addr); end
    step();
    checks++; if (pc !== 32'h40 || taken_cnt !== 16'd1 || instr_cnt !== 32'd5) begin
      errors++; $display("FAIL call_post: got pc=%h tk=%0d ic=%0d want 40/1/5", pc, taken_cnt, instr_cnt); end
  endtask

  task automatic test_not_taken_stall();
    is_jmp = 1'b1; is_call = 1'b1; valid_jmp = 1'b0; jmp_target = 32'h80;
    #1;
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL nt_link: got %b want 0", link_we); end
    step();
    checks++; if (pc !== 32'h44 || instr_cnt !== 32'd6 || taken_cnt !== 16'd1) begin
      errors++; $display("FAIL nt_post: got pc=%h ic=%0d tk=%0d want 44/6/1", pc, instr_cnt, taken_cnt); end
    en = 1'b0; valid_jmp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL stall_link: got %b want 0", link_we); end
      step();
      checks++; if (pc !== 32'h44 || instr_cnt !== 32'd6 || taken_cnt !== 16'd1) begin
        errors++; $display("FAIL stall_hold: got pc=%h ic=%0d tk=%0d want 44/6/1", pc, instr_cnt, taken_cnt); end
    end
  endtask

  task automatic test_halt_priority();
    en = 1'b1; halt_req = 1'b1; is_jmp = 1'b1; is_call = 1'b1; valid_jmp = 1'b1; jmp_target = 32'h80;
    #1;
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL halt_link: got %b want 0", link_we); end
    step();
    checks++; if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'h44 || taken_cnt !== 16'd1 || instr_cnt !== 32'd7) begin
      errors++; $display("FAIL halt_post: got h=%b fv=%b pc=%h tk=%0d ic=%0d want 1/0/44/1/7", halted, fetch_valid, pc, taken_cnt, instr_cnt); end
    for (int i = 0; i < 5; i++) begin
      halt_req = i[0]; is_jmp = 1'b1; valid_jmp = 1'b1; en = ~i[1]; jmp_target = 32'h100 + 32'(i * 4);
      step();
      checks++; if (halted !== 1'b1 || pc !== 32'h44 || taken_cnt !== 16'd1 || instr_cnt !== 32'd7 || link_we !== 1'b0) begin
        errors++; $display("FAIL halt_frozen: got h=%b pc=%h tk=%0d ic=%0d lw=%b want 1/44/1/7/0", halted, pc, taken_cnt, instr_cnt, link_we); end
    end
  endtask

  task automatic restart();
    idle_inputs();
    #2 rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_misaligned();
    restart();
    step();
    checks++; if (pc !== 32'd4 || instr_cnt !== 32'd1) begin
      errors++; $display("FAIL mis_pre: got pc=%h ic=%0d want 4/1", pc, instr_cnt); end
    is_jmp = 1'b1; is_call = 1'b1; valid_jmp = 1'b1; jmp_target = 32'h102;
    #1;
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL mis_link: got %b want 0", link_we); end
    step();
    checks++; if (align_err !== 1'b1 || halted !== 1'b1 || pc !== 32'd4 || instr_cnt !== 32'd1 || taken_cnt !== 16'd0) begin
      errors++; $display("FAIL mis_post: got ae=%b h=%b pc=%h ic=%0d tk=%0d want 1/1/4/1/0", align_err, halted, pc, instr_cnt, taken_cnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if (pc !== 32'd0 || align_err !== 1'b0 || halted !== 1'b0 || fetch_valid !== 1'b0 || instr_cnt !== 32'd0 || taken_cnt !== 16'd0) begin
      errors++; $display("FAIL async_rst: got pc=%h ae=%b h=%b fv=%b ic=%0d tk=%0d want all 0", pc, align_err, halted, fetch_valid, instr_cnt, taken_cnt); end
  endtask

  task automatic test_wrap_sat();
    restart();
    is_jmp = 1'b1; valid_jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC || taken_cnt !== 16'd1) begin
      errors++; $display("FAIL wrap_jmp: got pc=%h tk=%0d want fffffffc/1", pc, taken_cnt); end
    // stray is_call/valid_jmp without is_jmp must act as a plain step
    is_jmp = 1'b0; is_call = 1'b1; valid_jmp = 1'b1; jmp_target = 32'h200;
    #1;
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL nojmp_link: got %b want 0", link_we); end
    step();
    checks++; if (pc !== 32'd0 || instr_cnt !== 32'd2 || taken_cnt !== 16'd1) begin
      errors++; $display("FAIL wrap_step: got pc=%h ic=%0d tk=%0d want 0/2/1", pc, instr_cnt, taken_cnt); end
    is_jmp = 1'b1; is_call = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      jmp_target = {18'd0, i[11:0], 2'b00};
      step();
    end
    checks++; if (taken_cnt !== 16'hFFFF || instr_cnt !== 32'd65536) begin
      errors++; $display("FAIL sat_reach: got tk=%h ic=%0d want ffff/65536", taken_cnt, instr_cnt); end
    jmp_target = 32'h300;
    step();
    checks++; if (taken_cnt !== 16'hFFFF || instr_cnt !== 32'd65537 || pc !== 32'h300) begin
      errors++; $display("FAIL sat_hold: got tk=%h ic=%0d pc=%h want ffff/65537/300", taken_cnt, instr_cnt, pc); end
  endtask

  initial begin
    test_reset();
    test_taken_call();
    test_not_taken_stall();
    test_halt_priority();
    test_misaligned();
    test_wrap_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and next-address sequencer for the single-cycle datapath. It sits directly downstream of the branch-decision stage. It consumes `valid_jmp` together with the decoded jump class and target, and holds the architectural PC. Each cycle it selects sequential or jump address, produces the link address for call-type jumps, and manages run/stall/halt state. It also keeps retired-instruction and taken-jump counters.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `CNT_W`, 16: width of the taken-jump counter.

Ports:
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous assert, active-low.
- `en` input 1: advance enable; low = stall (all state held).
- `halt_req` input 1: decoded halt instruction in the current cycle.
- `is_jmp` input 1: current instruction is any jump/branch class.
- `is_call` input 1: current jump writes a link address (qualified by `is_jmp`).
- `valid_jmp` input 1: branch-decision result for the current instruction.
- `jmp_target` input 32: jump destination byte address.
- `pc` output 32: current instruction address.
- `pc_plus4` output 32: `pc + 4` (combinational, modulo 2^32).
- `link_we` output 1: link-register write strobe (combinational).
- `link_addr` output 32: value to write on `link_we`, equals `pc_plus4`.
- `fetch_valid` output 1: `pc` addresses an instruction to execute this cycle.
- `halted` output 1: sequencer is in HALT.
- `align_err` output 1: sticky error flag for a misaligned jump target.
- `instr_cnt` output 32: retired-instruction count.
- `taken_cnt` output CNT_W: taken-jump count.

## Operation
- FSM states are BOOT, RUN and HALT. Reset enters BOOT.
- **BOOT.** Lasts exactly one cycle after `rst` deasserts, and `fetch_valid`=0 during it. The next state is RUN unconditionally; `en` is ignored in BOOT.
- **RUN.** `fetch_valid`=1. An instruction retires on an edge where `en`=1, with these priorities:
  1. If `halt_req`=1, go to HALT. `pc` holds, no jump is taken, and `instr_cnt` increments (the halt instruction retires).
  2. Else if `is_jmp`=1 and `valid_jmp`=1, it is a taken jump.
     - If `jmp_target[1:0]`≠0: set `align_err`, go to HALT, `pc` holds, counters unchanged.
     - Otherwise: `pc`←`jmp_target`, `taken_cnt` increments (saturating at all-ones), `instr_cnt` increments.
  3. Otherwise, `pc`←`pc_plus4` (wraps 32'hFFFF_FFFC→0) and `instr_cnt` increments (wrapping).
- **Stall.** With `en`=0 in RUN, every register holds and `link_we`=0.
- **Link write.** `link_we` = RUN & `en` & `is_jmp` & `is_call` & `valid_jmp` & ~`halt_req` & (`jmp_target[1:0]`==0).
- **`is_call` without `is_jmp`.** Ignored.
- **`valid_jmp` with `is_jmp`=0.** Ignored; the result is a sequential step.
- **HALT.** `fetch_valid`=0 and `halted`=1; all inputs are ignored and `pc` and the counters are frozen. The only exit is reset.
- **Reset values.** Assertion of `rst` (low) at any time, including mid-stall or in HALT, sets:
  - `pc`=`RESET_PC`, state=BOOT;
  - `instr_cnt`=0, `taken_cnt`=0, `align_err`=0;
  - `halted`=0, `fetch_valid`=0, `link_we`=0.

## Timing
- Input-to-state latency is one cycle: inputs sampled at edge N determine `pc` after edge N.
- `pc_plus4`, `link_addr`, `link_we` and `fetch_valid` are combinational from the registered state and the current inputs. There is no registered output delay.
- The first instruction at `RESET_PC` is presented with `fetch_valid`=1 in the second cycle after reset release.
- `halted` and `align_err` rise in the cycle after the triggering edge.
- Reset assertion acts without waiting for a clock edge.
- Release of `rst` is synchronised externally; it is not this block's concern.

## Test plan
- **Reset/boot.** Release `rst` with `RESET_PC`=0 and `en`=1, no jumps for 3 cycles. Required: `fetch_valid` 0,1,1,1; `pc` 0,0,4,8; `instr_cnt`=2 after the third edge.
- **Taken call.** In RUN at `pc`=0x10, drive `is_jmp`=1, `is_call`=1, `valid_jmp`=1, `jmp_target`=0x40. Required: `link_we`=1 with `link_addr`=0x14 during the cycle; next `pc`=0x40; `taken_cnt`=1.
- **Not-taken branch, then stall.** First drive `is_jmp`=1, `valid_jmp`=0 at `pc`=0x40; then hold `en`=0 for 2 cycles. Required: `pc`=0x44 and stays 0x44; counters are unchanged during the stall; `link_we`=0.
- **Halt priority.** Drive `halt_req`=1 together with a taken jump to 0x80 at `pc`=0x44. Required: `halted`=1, `pc` stays 0x44, `taken_cnt` is unchanged, `instr_cnt`+1, and no further change for 5 cycles regardless of inputs.
- **Misaligned target.** Drive a taken jump to 0x102. Required: `align_err`=1, `halted`=1, `pc` holds, `link_we`=0. Then assert `rst` mid-cycle: required `pc`=`RESET_PC` and all flags/counters 0 without a clock edge.
- **Wrap and saturation.** Force `pc`=0xFFFF_FFFC via a jump, then step once: required `pc`=0. Drive `taken_cnt` to 0xFFFF, then take one more jump: required `taken_cnt` holds at 0xFFFF.
